// File: rtl/regs_wr_arbiter.sv
// Two-requester round-robin write arbiter in front of a 16x8 register file.
// Optional grant counters enabled by defining REGS_WR_ARBITER_STATS_EN.
module regs_wr_arbiter #(
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [3:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  input  logic       clear_req,
  output logic       busy,
  output logic       rf_we,
  output logic       rf_rst,
  output logic [3:0] rf_w_addr,
  output logic [7:0] rf_w_data
`ifdef REGS_WR_ARBITER_STATS_EN
  ,
  output logic [15:0] gnt0_cnt,
  output logic [15:0] gnt1_cnt
`endif
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] cnt_q;
  logic       rr_q;
  logic       run_open;
  logic       acc0;
  logic       acc1;

  // State register
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CLEAR: if (cnt_q == 4'hF) state_d = ST_RUN;
      ST_RUN:   if (clear_req) state_d = ST_CLEAR;
      default:  state_d = state_q;
    endcase
  end

  // Output logic: grants only open in RUN with no clear pending
  always_comb begin
    busy       = (state_q == ST_CLEAR);
    run_open   = (state_q == ST_RUN) && !rst && !clear_req;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (run_open) begin
      unique case (1'b1)
        req0_valid && req1_valid: begin
          req0_ready = !rr_q;
          req1_ready = rr_q;
        end
        req0_valid && !req1_valid: req0_ready = 1'b1;
        !req0_valid && req1_valid: req1_ready = 1'b1;
        default: ;
      endcase
    end
  end

  assign acc0 = req0_valid && req0_ready;
  assign acc1 = req1_valid && req1_ready;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else if (state_q == ST_CLEAR) begin
      cnt_q <= cnt_q + 4'd1;
    end else if (clear_req) begin
      cnt_q <= 4'd0;
    end
  end

  // Pointer favours the loser of the last accept
  always_ff @(posedge clk_in) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else if (acc0) begin
      rr_q <= 1'b1;
    end else if (acc1) begin
      rr_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      rf_we     <= 1'b0;
      rf_rst    <= 1'b0;
      rf_w_addr <= 4'd0;
      rf_w_data <= 8'd0;
    end else if (state_q == ST_CLEAR) begin
      rf_we     <= 1'b1;
      rf_rst    <= 1'b1;
      rf_w_addr <= cnt_q;
      rf_w_data <= 8'd0;
    end else if (acc0) begin
      rf_we     <= 1'b1;
      rf_rst    <= 1'b0;
      rf_w_addr <= req0_addr;
      rf_w_data <= req0_data;
    end else if (acc1) begin
      rf_we     <= 1'b1;
      rf_rst    <= 1'b0;
      rf_w_addr <= req1_addr;
      rf_w_data <= req1_data;
    end else begin
      rf_we  <= 1'b0;
      rf_rst <= 1'b0;
    end
  end

`ifdef REGS_WR_ARBITER_STATS_EN
  always_ff @(posedge clk_in) begin
    if (rst) begin
      gnt0_cnt <= 16'd0;
      gnt1_cnt <= 16'd0;
    end else begin
      if (acc0 && gnt0_cnt != 16'hFFFF) gnt0_cnt <= gnt0_cnt + 16'd1;
      if (acc1 && gnt1_cnt != 16'hFFFF) gnt1_cnt <= gnt1_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regs_wr_arbiter.sv
// Directed bench for regs_wr_arbiter: clear sweep, arbitration, reset.
// Grant counters are checked when REGS_WR_ARBITER_STATS_EN is defined.
module tb_regs_wr_arbiter;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_addr, req1_addr;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       clear_req;
  logic       busy;
  logic       rf_we, rf_rst;
  logic [3:0] rf_w_addr;
  logic [7:0] rf_w_data;
`ifdef REGS_WR_ARBITER_STATS_EN
  logic [15:0] gnt0_cnt, gnt1_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  regs_wr_arbiter #(.CLEAR_ON_RESET(1)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .clear_req  (clear_req),
    .busy       (busy),
    .rf_we      (rf_we),
    .rf_rst     (rf_rst),
    .rf_w_addr  (rf_w_addr),
    .rf_w_data  (rf_w_data)
`ifdef REGS_WR_ARBITER_STATS_EN
    ,
    .gnt0_cnt   (gnt0_cnt),
    .gnt1_cnt   (gnt1_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic rr,
                        input logic [3:0] a, input logic [7:0] d);
    chk({tag, "_we"}, {31'd0, rf_we}, {31'd0, we});
    chk({tag, "_rst"}, {31'd0, rf_rst}, {31'd0, rr});
    chk({tag, "_addr"}, {28'd0, rf_w_addr}, {28'd0, a});
    chk({tag, "_data"}, {24'd0, rf_w_data}, {24'd0, d});
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    chk({tag, "_r0"}, {31'd0, req0_ready}, {31'd0, r0});
    chk({tag, "_r1"}, {31'd0, req1_ready}, {31'd0, r1});
  endtask

  initial begin
    rst = 1'b1;
    clear_req = 1'b0;
    req0_valid = 1'b1; req0_addr = 4'd0; req0_data = 8'd0;
    req1_valid = 1'b1; req1_addr = 4'd0; req1_data = 8'd0;
    tick();
    tick();
    chk_wr("reset", 1'b0, 1'b0, 4'd0, 8'd0);
    chk_rdy("reset_rdy", 1'b0, 1'b0);
    chk("reset_busy", {31'd0, busy}, 32'd1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;

    // Power-up sweep; a clear_req mid-sweep must be ignored
    for (int i = 0; i < 16; i++) begin
      chk("sweep_busy", {31'd0, busy}, 32'd1);
      clear_req = (i == 5);
      tick();
      clear_req = 1'b0;
      chk_wr("sweep", 1'b1, 1'b1, i[3:0], 8'd0);
    end
    chk("sweep_done_busy", {31'd0, busy}, 32'd0);
    tick();
    chk_wr("idle", 1'b0, 1'b0, 4'd15, 8'd0);

    // Single req0 write
    req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 8'hA5;
    #1;
    chk_rdy("single0", 1'b1, 1'b0);
    tick();
    chk_wr("single0_wr", 1'b1, 1'b0, 4'd3, 8'hA5);
    req0_valid = 1'b0;

    // Single req1 write returns pointer to requester 0
    req1_valid = 1'b1; req1_addr = 4'd9; req1_data = 8'h5C;
    #1;
    chk_rdy("single1", 1'b0, 1'b1);
    tick();
    chk_wr("single1_wr", 1'b1, 1'b0, 4'd9, 8'h5C);
    req1_valid = 1'b0;
    #1;
    chk_rdy("noval", 1'b0, 1'b0);

    // Sustained contention alternates 0,1,0,1
    req0_valid = 1'b1; req0_addr = 4'd1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_addr = 4'd2; req1_data = 8'h22;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_rdy("contend", (k % 2) == 0, (k % 2) == 1);
      tick();
      if ((k % 2) == 0) chk_wr("contend_wr", 1'b1, 1'b0, 4'd1, 8'h11);
      else chk_wr("contend_wr", 1'b1, 1'b0, 4'd2, 8'h22);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    chk_wr("hold", 1'b0, 1'b0, 4'd2, 8'h22);

    // clear_req beats a pending req1, which is served after the sweep
    clear_req = 1'b1;
    req1_valid = 1'b1; req1_addr = 4'd4; req1_data = 8'h44;
    #1;
    chk_rdy("clr_req", 1'b0, 1'b0);
    tick();
    clear_req = 1'b0;
    chk("clr_we", {31'd0, rf_we}, 32'd0);
    chk("clr_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("clr_sweep_r1", {31'd0, req1_ready}, 32'd0);
      tick();
      chk_wr("clr_sweep", 1'b1, 1'b1, i[3:0], 8'd0);
    end
    chk_rdy("after_clr", 1'b0, 1'b1);
    chk("after_clr_busy", {31'd0, busy}, 32'd0);
    tick();
    chk_wr("after_clr_wr", 1'b1, 1'b0, 4'd4, 8'h44);
    req1_valid = 1'b0;

    // Reset mid-sweep at address 7 restarts from 0
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk_wr("mid_sweep", 1'b1, 1'b1, 4'd7, 8'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_wr("mid_rst", 1'b0, 1'b0, 4'd0, 8'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk_wr("resweep", 1'b1, 1'b1, i[3:0], 8'd0);
    end
    chk("resweep_busy", {31'd0, busy}, 32'd0);

    // Three req0 accepts after reset
    req0_valid = 1'b1; req0_addr = 4'd6; req0_data = 8'h66;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_rdy("post_rst0", 1'b1, 1'b0);
      tick();
      chk_wr("post_rst0_wr", 1'b1, 1'b0, 4'd6, 8'h66);
    end
    req0_valid = 1'b0;
`ifdef REGS_WR_ARBITER_STATS_EN
    chk("gnt0_cnt", {16'd0, gnt0_cnt}, 32'd3);
    chk("gnt1_cnt", {16'd0, gnt1_cnt}, 32'd0);
`endif

    // Readies are blocked during reset in RUN
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk_rdy("rst_in_run", 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("rst_in_run_busy", {31'd0, busy}, 32'd1);
    chk_wr("rst_in_run_wr", 1'b0, 1'b0, 4'd0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regs_wr_arbiter.md
REGS_WR_ARBITER -- requirements
Module: regs_wr_arbiter

Interface
REQ-001 SHALL have parameter: CLEAR_ON_RESET, default 1, 1 = run the 16-entry clear sweep after reset, 0 = go straight to RUN.
REQ-002 SHALL have port: clk_in  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: req0_valid / req1_valid  in  1  write request from requester 0 / 1.
REQ-005 SHALL have ports: req0_addr / req1_addr  in  4  target register index.
REQ-006 SHALL have ports: req0_data / req1_data  in  8  write data.
REQ-007 SHALL have ports: req0_ready / req1_ready  out  1  request accepted this cycle; combinational.
REQ-008 SHALL have port: clear_req  in  1  single-cycle request to zero all 16 registers.
REQ-009 SHALL have port: busy  out  1  high while in CLEAR state; combinational from state.
REQ-010 SHALL have ports to register file: rf_we  out  1, rf_rst  out  1, rf_w_addr  out  4, rf_w_data  out  8; all registered.

Function
REQ-011 SHALL implement states CLEAR and RUN, plus a 4-bit sweep counter cnt and a 1-bit round-robin pointer rr.
REQ-012 In CLEAR, each edge SHALL drive rf_we=1, rf_rst=1, rf_w_addr=cnt, rf_w_data=0, then cnt=cnt+1.
REQ-013 In CLEAR with cnt==15, the edge SHALL also move the state to RUN; a sweep is exactly 16 writes, addresses 0..15 in order.
REQ-014 In CLEAR, req0_ready and req1_ready SHALL be 0, and clear_req SHALL be ignored (no sweep restart).
REQ-015 In RUN with clear_req=1, both readies SHALL be 0 that cycle, the state SHALL go to CLEAR with cnt=0, and rf_we SHALL be 0 on that edge.
REQ-016 In RUN without clear_req, if exactly one valid is high, that requester SHALL get ready=1.
REQ-017 In RUN without clear_req, if both valids are high, requester rr SHALL get ready=1 and the other ready=0.
REQ-018 A ready SHALL never assert while its valid is low.
REQ-019 On an accept (valid&ready), the next edge SHALL drive rf_we=1, rf_rst=0, rf_w_addr/rf_w_data = winner's addr/data, and set rr = ~winner index.
REQ-020 A write SHALL appear one cycle after its accept, at a rate of at most one write per cycle.
REQ-021 In RUN with no accept, the edge SHALL drive rf_we=0 and rf_rst=0, with rf_w_addr and rf_w_data holding their values.
REQ-022 rr SHALL change only on an accept, so sustained contention alternates strictly 0,1,0,1...
REQ-023 Requesters SHALL hold valid/addr/data stable until accepted; the block SHALL NOT buffer rejected requests.

Reset
REQ-024 While rst=1 at an edge, the block SHALL set rf_we=0, rf_rst=0, rf_w_addr=0, rf_w_data=0, cnt=0, rr=0.
REQ-025 While rst=1 at an edge, state SHALL be set to CLEAR if CLEAR_ON_RESET=1, else to RUN.
REQ-026 A reset asserted mid-sweep or mid-RUN SHALL abandon the current operation; the sweep SHALL restart from address 0.
REQ-027 Readies SHALL be 0 during any cycle with rst=1.

Configuration
REQ-028 With macro REGS_WR_ARBITER_STATS_EN defined, the block SHALL add output ports gnt0_cnt and gnt1_cnt (16 bits each).
REQ-029 Each gntN_cnt SHALL increment on every accept for requester N, saturate at 0xFFFF, and clear only on rst.
REQ-030 Without REGS_WR_ARBITER_STATS_EN, those ports and counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 Release rst, no requests (CLEAR_ON_RESET=1) -> rf_we=1, rf_rst=1, addr 0..15 on 16 consecutive edges; busy falls after the 16th; then rf_we=0.
REQ-032 After the sweep, req0 valid addr=3 data=0xA5 for one accept -> req0_ready=1 that cycle; next edge rf_we=1, rf_rst=0, addr=3, data=0xA5.
REQ-033 Both valid continuously (req0 addr 1 data 0x11, req1 addr 2 data 0x22), 4 accepts -> write order 1,2,1,2; readies never both high.
REQ-034 clear_req in the same cycle as req1 valid in RUN -> req1_ready=0, 16-write sweep follows; req1 accepted on the first RUN cycle after the sweep.
REQ-035 rst pulsed while the sweep is at addr 7 -> the sweep restarts at addr 0; with STATS_EN, after 3 req0 accepts gnt0_cnt=3, gnt1_cnt=0.
